// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
//   state_t   : FSM states IDLE -> RUN -> DONE -> IDLE
//   DEF_WIDTH : default operand/result width
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned DEF_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_cell.sv
// full_sub_cell: combinational one-bit full subtractor, d = a - b - bi.
//   a  : minuend bit
//   b  : subtrahend bit
//   bi : borrow in
//   d  : difference bit
//   bo : borrow out
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    always_comb begin
        d  = a ^ b ^ bi;
        // Borrow when b exceeds a, or when a == b and a borrow is pending.
        bo = (~a & b) | (~(a ^ b) & bi);
    end

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial subtractor, diff = a - b - bin, LSB first, one bit per clock.
// A single full_sub_cell is reused on every RUN cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   start : request, only sampled in IDLE
//   a, b  : minuend / subtrahend, captured on accept
//   bin   : borrow in, captured on accept
//   busy  : high while in RUN
//   done  : one-cycle pulse; diff/bout valid then and held until the next accept
//   diff  : a - b - bin modulo 2^WIDTH
//   bout  : borrow out (unsigned underflow)
//   ovf   : signed overflow, only present when SERIAL_SUB_OVF_EN is defined
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic [CntW-1:0]  cnt_q;
    logic             br_q;
    logic             bout_q;
    logic             busy_q;
    logic             done_q;
    logic             cell_d;
    logic             cell_bo;

    full_sub_cell u_cell (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .bi (br_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are shifted out during RUN, so keep copies.
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == IDLE && start) begin
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
        end else if (state_q == DONE) begin
            ovf_q <= (a_msb_q != b_msb_q) && (diff_q[WIDTH-1] != a_msb_q);
        end
    end

    assign ovf = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // Result bits enter at the MSB and walk down to the LSB.
                    diff_q <= {cell_d, diff_q[WIDTH-1:1]};
                    a_q    <= a_q >> 1;
                    b_q    <= b_q >> 1;
                    br_q   <= cell_bo;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    bout_q  <= br_q;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8). Expected results come from
// plain 9-bit arithmetic; covers directed cases, start-while-busy, mid-RUN reset and
// random operands. Define SERIAL_SUB_OVF_EN to also check the ovf output.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       bin = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
        .ovf   (ovf),
`endif
        .bout  (bout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check latency, busy span, result and the done pulse width.
    // With poke set, a second start (a=AA) is raised during RUN and must be ignored.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                         input bit poke, input string tag);
        logic [8:0] full;
        int         n;
        int         busy_cnt;
        bit         seen;
        full = {1'b0, av} - {1'b0, bv} - {8'd0, bi};
        @(negedge clk);
        a = av;
        b = bv;
        bin = bi;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Operands must already be captured.
        a = 8'($urandom);
        b = 8'($urandom);
        bin = 1'($urandom);
        busy_cnt = busy ? 1 : 0;
        seen = 1'b0;
        for (n = 1; n <= 20; n++) begin
            if (poke && n == 3) begin
                start = 1'b1;
                a = 8'hAA;
            end
            if (poke && n == 4) start = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'd9);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_diff"}, 32'(diff), 32'(full[7:0]));
        chk({tag, "_bout"}, 32'(bout), 32'(full[8]));
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'((av[7] != bv[7]) && (full[7] != av[7])));
`endif
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_diff_hold"}, 32'(diff), 32'(full[7:0]));
        chk({tag, "_bout_hold"}, 32'(bout), 32'(full[8]));
    endtask

    initial begin
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        do_op(8'h07, 8'h03, 1'b0, 1'b0, "t1");
        do_op(8'h03, 8'h07, 1'b0, 1'b0, "t2");
        do_op(8'h00, 8'h00, 1'b1, 1'b0, "t3_wrap");
        do_op(8'h80, 8'h01, 1'b0, 1'b0, "t4");
        do_op(8'h10, 8'h01, 1'b0, 1'b1, "t5_start_busy");

        // Reset during RUN: outputs clear at once and done never fires.
        @(negedge clk);
        a = 8'h55;
        b = 8'h22;
        bin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_diff", 32'(diff), 32'd0);
        chk("t6_bout", 32'(bout), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk("t6_no_done", 32'(done), 32'd0);
            chk("t6_idle", 32'(busy), 32'd0);
        end
        do_op(8'h55, 8'h22, 1'b0, 1'b0, "t6_after");

        for (int i = 0; i < 20; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
